// File: rtl/hex_ascii_tx_formatter.sv
// hex_ascii_tx_formatter
// Turns a DATA_W-bit word into printable hexadecimal ASCII characters for a
// UART transmitter byte interface. The most significant nibble is sent first,
// one character per valid/ready transfer. An optional CR/LF pair closes each
// frame. This block performs the reverse of the RX-side ASCII-to-nibble decode.
//
// Frame:  IDLE -> DIGIT (DATA_W/4 chars) -> [CR -> LF] -> IDLE
// The block accepts a word only in IDLE. tx_byte and tx_valid are registered,
// so the first character is valid in the cycle after the word is accepted.
// When tx_ready is held high, every character of a frame transfers on
// consecutive cycles. After the final transfer there is one idle cycle in
// which in_ready is high before the next frame can start.

module hex_ascii_tx_formatter #(
    parameter int DATA_W      = 16,    // word width, multiple of 4, >= 4
    parameter bit UPPERCASE   = 1'b1,  // 1: 'A'-'F', 0: 'a'-'f'
    parameter bit APPEND_CRLF = 1'b1   // 1: terminate each frame with CR, LF
) (
    input  logic              clk,
    input  logic              rst,       // synchronous, active-high
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int NIBBLES = DATA_W / 4;
    // A single-nibble word still needs a 1-bit counter to keep the vector legal.
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam logic [7:0] CHAR_NONE = 8'h00;

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DIGIT = 2'd1;
    localparam logic [1:0] ST_CR    = 2'd2;
    localparam logic [1:0] ST_LF    = 2'd3;

    // Reject illegal widths at elaboration rather than emit garbage nibbles.
    generate
        if ((DATA_W < 4) || ((DATA_W % 4) != 0)) begin : g_bad_width
            $error("hex_ascii_tx_formatter: DATA_W must be a multiple of 4 and >= 4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state;
    logic [DATA_W-1:0] shift_reg;   // remaining nibbles, current one at the top
    logic [CNT_W-1:0]  nib_cnt;     // nibbles left after the one on tx_byte
    logic [7:0]        tx_byte_q;
    logic              tx_valid_q;

    // ------------------------------------------------------------------
    // Handshake and datapath helpers
    // ------------------------------------------------------------------
    logic              accept;      // word captured this edge
    logic              xfer;        // character consumed this edge
    logic              last_digit;  // character on tx_byte is the final nibble
    logic [DATA_W-1:0] shift_next;
    logic [7:0]        first_char;
    logic [7:0]        next_char;

    // Map one nibble to its ASCII hex digit.
    function automatic logic [7:0] encode_nibble(input logic [3:0] nib);
        logic [7:0] nib8;
        nib8 = {4'h0, nib};
        if (nib <= 4'd9) begin
            return 8'h30 + nib8;
        end else if (UPPERCASE) begin
            return 8'h41 + (nib8 - 8'd10);
        end else begin
            return 8'h61 + (nib8 - 8'd10);
        end
    endfunction

    // While rst is high, in_ready stays low, so no word can be lost to a
    // capture that reset immediately discards.
    assign in_ready   = (state == ST_IDLE) & ~rst;
    assign accept     = in_valid & in_ready;
    assign xfer       = tx_valid_q & tx_ready;
    assign last_digit = (nib_cnt == CNT_ZERO);

    // The first character is encoded directly from in_data. It is registered in
    // the same edge as the shift register, which keeps the latency at one cycle.
    assign shift_next = shift_reg << 4;
    assign first_char = encode_nibble(in_data[DATA_W-1 -: 4]);
    assign next_char  = encode_nibble(shift_next[DATA_W-1 -: 4]);

    assign tx_byte  = tx_byte_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state != ST_IDLE);

    // Frame sequencer: capture a word, then walk nibbles, CR and LF one transfer at a time.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: registered state uses non-blocking assignments so every flop
            // samples the pre-edge values. The datapath registers are also
            // cleared so a reset leaves no stale characters behind.
            state      <= ST_IDLE;
            shift_reg  <= '0;
            nib_cnt    <= CNT_ZERO;
            tx_byte_q  <= CHAR_NONE;
            tx_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shift_reg  <= in_data;
                        nib_cnt    <= CNT_LAST;
                        tx_byte_q  <= first_char;
                        tx_valid_q <= 1'b1;
                        state      <= ST_DIGIT;
                    end
                end

                ST_DIGIT: begin
                    if (xfer) begin
                        if (last_digit) begin
                            if (APPEND_CRLF) begin
                                tx_byte_q <= CHAR_CR;
                                state     <= ST_CR;
                            end else begin
                                tx_byte_q  <= CHAR_NONE;
                                tx_valid_q <= 1'b0;
                                state      <= ST_IDLE;
                            end
                        end else begin
                            shift_reg <= shift_next;
                            nib_cnt   <= nib_cnt - CNT_ONE;
                            tx_byte_q <= next_char;
                        end
                    end
                end

                ST_CR: begin
                    if (xfer) begin
                        tx_byte_q <= CHAR_LF;
                        state     <= ST_LF;
                    end
                end

                ST_LF: begin
                    if (xfer) begin
                        tx_byte_q  <= CHAR_NONE;
                        tx_valid_q <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    tx_byte_q  <= CHAR_NONE;
                    tx_valid_q <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
